// File: rtl/seq_alu_if.sv
// Request/response bundle between the complement stage, the sequential ALU and its consumer.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] data2_neg;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             err;

    modport master (
        output start, opcode, data1, data2, data2_neg,
        input  busy, done, result, zero, carry, ovf, err
    );

    modport slave (
        input  start, opcode, data1, data2, data2_neg,
        output busy, done, result, zero, carry, ovf, err
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU stage: single-cycle logic/arith ops plus a WIDTH-step shift-add multiplier.
// state  | meaning
// IDLE   | waiting for start; result and flags hold
// EXEC   | single-cycle op latched, completes on next edge
// MUL    | shift-add step per edge, completes when count reaches WIDTH-1
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    seq_alu_if.slave bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam int             MSB  = WIDTH - 1;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t             state, state_nxt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   d1_q, d2_q, neg_q;
    logic [2*WIDTH-1:0] prod, mcand, prod_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               accept;

    logic               fin;
    logic [WIDTH-1:0]   res_c;
    logic               carry_c, ovf_c, err_c;
    logic [WIDTH:0]     sum;

    logic               done_q, zero_q, carry_q, ovf_q, err_q;
    logic [WIDTH-1:0]   result_q;

    assign accept = (state == S_IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = (bus.opcode == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC: state_nxt = S_IDLE;
            S_MUL:  if (count == LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands are captured on accept so later input changes cannot disturb the op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            neg_q  <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (accept) begin
            op_q   <= bus.opcode;
            d1_q   <= bus.data1;
            d2_q   <= bus.data2;
            neg_q  <= bus.data2_neg;
            prod   <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.data1};
            mplier <= bus.data2;
            count  <= '0;
        end else if (state == S_MUL) begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

    always_comb begin
        fin      = 1'b0;
        res_c    = '0;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        err_c    = 1'b0;
        sum      = '0;
        prod_nxt = prod + (mplier[0] ? mcand : '0);
        case (state)
            S_EXEC: begin
                fin = 1'b1;
                case (op_q)
                    OP_MOV: res_c = d2_q;
                    OP_ADD: begin
                        sum     = {1'b0, d1_q} + {1'b0, d2_q};
                        res_c   = sum[WIDTH-1:0];
                        carry_c = sum[WIDTH];
                        ovf_c   = (d1_q[MSB] == d2_q[MSB]) && (sum[MSB] != d1_q[MSB]);
                    end
                    OP_SUB: begin
                        // Overflow is judged against the raw subtrahend, not its negation.
                        sum     = {1'b0, d1_q} + {1'b0, neg_q};
                        res_c   = sum[WIDTH-1:0];
                        carry_c = sum[WIDTH];
                        ovf_c   = (d1_q[MSB] != d2_q[MSB]) && (sum[MSB] != d1_q[MSB]);
                    end
                    OP_AND: res_c = d1_q & d2_q;
                    OP_OR:  res_c = d1_q | d2_q;
                    default: err_c = 1'b1;
                endcase
            end
            S_MUL: begin
                if (count == LAST) begin
                    fin     = 1'b1;
                    res_c   = prod_nxt[WIDTH-1:0];
                    carry_c = |prod_nxt[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= fin;
            if (fin) begin
                result_q <= res_c;
                zero_q   <= (res_c == '0);
                carry_q  <= carry_c;
                ovf_q    <= ovf_c;
                err_q    <= err_c;
            end
        end
    end

    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;
    assign bus.ovf    = ovf_q;
    assign bus.err    = err_q;
endmodule
